// File: rtl/la_iopwrseq.sv
// la_iopwrseq: power-up/down sequencer for one IO ring segment.
// Steps the ring enables (en_h, vswitch, hold) and the core reset in a fixed
// order with a programmable settle delay between steps.
// Optional build macro LA_IOPWRSEQ_STATUS_EN adds brownout and event_cnt outputs.
module la_iopwrseq #(
  parameter int unsigned DLYW  = 8,
  parameter int unsigned DLY   = 100,
  parameter int unsigned SYNCN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vddio_good,
  input  logic       vdd_good,
  input  logic       shutdown,
`ifdef LA_IOPWRSEQ_STATUS_EN
  output logic       brownout,
  output logic [7:0] event_cnt,
`endif
  output logic       io_en_h,
  output logic       io_vswitch,
  output logic       io_hold,
  output logic       core_nreset,
  output logic       seq_ready
);

  localparam logic [DLYW-1:0] CNT_LAST = DLYW'(DLY - 1);
  localparam logic [DLYW-1:0] CNT_MAX  = {DLYW{1'b1}};

  typedef enum logic [2:0] {
    S_OFF, S_IO_UP, S_VSW_UP, S_UNHOLD, S_ON, S_DOWN_HOLD, S_DOWN_VSW, S_DOWN_IO
  } state_t;

  state_t            state_q, state_d;
  logic [DLYW-1:0]   cnt_q, cnt_d;
  logic [SYNCN-1:0]  vsync_q, csync_q;
  logic              vg, cg, lost, step_done;
  logic              en_d, vsw_d, hold_d, nrst_d, rdy_d;

  assign vg        = vsync_q[SYNCN-1];
  assign cg        = csync_q[SYNCN-1];
  assign lost      = !vg || !cg;
  assign step_done = (cnt_q == CNT_LAST);

  // Synchronize the async supply-good detects into the clk domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q <= '0;
      csync_q <= '0;
    end else begin
      vsync_q <= {vsync_q[SYNCN-2:0], vddio_good};
      csync_q <= {csync_q[SYNCN-2:0], vdd_good};
    end
  end

  // State, settle counter and registered ring controls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_OFF;
      cnt_q       <= '0;
      io_en_h     <= 1'b0;
      io_vswitch  <= 1'b0;
      io_hold     <= 1'b1;
      core_nreset <= 1'b0;
      seq_ready   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      io_en_h     <= en_d;
      io_vswitch  <= vsw_d;
      io_hold     <= hold_d;
      core_nreset <= nrst_d;
      seq_ready   <= rdy_d;
    end
  end

  // Next-state, counter and output decode of the current state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    vsw_d   = 1'b0;
    hold_d  = 1'b1;
    nrst_d  = 1'b0;
    rdy_d   = 1'b0;
    unique case (state_q)
      S_OFF: begin
        if (vg && cg && !shutdown) state_d = S_IO_UP;
      end
      S_IO_UP: begin
        en_d = 1'b1;
        if (lost || shutdown)  state_d = S_DOWN_HOLD;
        else if (step_done)    state_d = S_VSW_UP;
      end
      S_VSW_UP: begin
        en_d  = 1'b1;
        vsw_d = 1'b1;
        if (lost || shutdown)  state_d = S_DOWN_HOLD;
        else if (step_done)    state_d = S_UNHOLD;
      end
      S_UNHOLD: begin
        en_d   = 1'b1;
        vsw_d  = 1'b1;
        hold_d = 1'b0;
        if (lost || shutdown)  state_d = S_DOWN_HOLD;
        else if (step_done)    state_d = S_ON;
      end
      S_ON: begin
        en_d   = 1'b1;
        vsw_d  = 1'b1;
        hold_d = 1'b0;
        nrst_d = 1'b1;
        rdy_d  = 1'b1;
        if (lost || shutdown)  state_d = S_DOWN_HOLD;
      end
      S_DOWN_HOLD: begin
        en_d  = 1'b1;
        vsw_d = 1'b1;
        if (step_done) state_d = S_DOWN_VSW;
      end
      S_DOWN_VSW: begin
        en_d = 1'b1;
        if (step_done) state_d = S_DOWN_IO;
      end
      S_DOWN_IO: begin
        if (step_done) state_d = S_OFF;
      end
      default: state_d = S_OFF;
    endcase
    // Counter restarts on every state entry and saturates otherwise
    if (state_d != state_q)    cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + DLYW'(1);
  end

`ifdef LA_IOPWRSEQ_STATUS_EN
  // Sticky brownout flag and saturating count of ON exits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brownout  <= 1'b0;
      event_cnt <= 8'd0;
    end else begin
      if (state_q != S_OFF && lost) brownout <= 1'b1;
      if (state_q == S_ON && state_d == S_DOWN_HOLD && event_cnt != 8'hFF)
        event_cnt <= event_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_la_iopwrseq.sv
// Bench for la_iopwrseq: two instances (settle 4 and settle 1) share stimulus
// and are compared every cycle against a step-table model of the sequence.
module tb_la_iopwrseq;

  localparam int SYNCN = 2;
  // {en_h, vswitch, hold, nreset, ready} per sequence step 0..7
  localparam logic [4:0] OUTTAB [8] = '{5'b00100, 5'b10100, 5'b11100, 5'b11000,
                                        5'b11011, 5'b11100, 5'b10100, 5'b00100};

  logic clk, reset, vio, vdd, sd;
  logic en4, vs4, hold4, nr4, rdy4;
  logic en1, vs1, hold1, nr1, rdy1;
  logic [4:0] o4, o1;
`ifdef LA_IOPWRSEQ_STATUS_EN
  logic bo4, bo1;
  logic [7:0] ev4, ev1;
`endif

  int errors = 0;
  int checks = 0;

  assign o4 = {en4, vs4, hold4, nr4, rdy4};
  assign o1 = {en1, vs1, hold1, nr1, rdy1};

  la_iopwrseq #(.DLYW(8), .DLY(4), .SYNCN(SYNCN)) u4 (
    .clk(clk), .reset(reset), .vddio_good(vio), .vdd_good(vdd), .shutdown(sd),
`ifdef LA_IOPWRSEQ_STATUS_EN
    .brownout(bo4), .event_cnt(ev4),
`endif
    .io_en_h(en4), .io_vswitch(vs4), .io_hold(hold4), .core_nreset(nr4), .seq_ready(rdy4));

  la_iopwrseq #(.DLYW(8), .DLY(1), .SYNCN(SYNCN)) u1 (
    .clk(clk), .reset(reset), .vddio_good(vio), .vdd_good(vdd), .shutdown(sd),
`ifdef LA_IOPWRSEQ_STATUS_EN
    .brownout(bo1), .event_cnt(ev1),
`endif
    .io_en_h(en1), .io_vswitch(vs1), .io_hold(hold1), .core_nreset(nr1), .seq_ready(rdy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               ph;    // sequence step 0..7
    int               left;  // cycles remaining in this step
    logic [SYNCN-1:0] sv;
    logic [SYNCN-1:0] sc;
    logic [4:0]       out;
    logic             bo;
    int               ev;
  } mdl_t;

  mdl_t m4, m1;

  function automatic mdl_t mreset();
    mdl_t r;
    r.ph = 0; r.left = 0; r.sv = '0; r.sc = '0;
    r.out = 5'b00100; r.bo = 1'b0; r.ev = 0;
    return r;
  endfunction

  // One clock of the model: outputs follow the step held before the edge
  function automatic mdl_t mstep(mdl_t m, int d, logic vin, logic cin, logic s);
    mdl_t r = m;
    logic lost;
    lost  = !m.sv[SYNCN-1] || !m.sc[SYNCN-1];
    r.out = OUTTAB[m.ph];
    if (m.ph != 0 && lost) r.bo = 1'b1;
    if (m.ph == 0) begin
      if (!lost && !s) begin r.ph = 1; r.left = d; end
    end else if (m.ph <= 4 && (lost || s)) begin
      if (m.ph == 4 && r.ev < 255) r.ev = m.ev + 1;
      r.ph = 5; r.left = d;
    end else if (m.ph != 4) begin
      r.left = m.left - 1;
      if (r.left == 0) begin
        r.ph = (m.ph == 7) ? 0 : m.ph + 1;
        r.left = d;
      end
    end
    r.sv = {m.sv[SYNCN-2:0], vin};
    r.sc = {m.sc[SYNCN-2:0], cin};
    return r;
  endfunction

  // Model advances on the same edges as the DUTs
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m4 = mreset();
      m1 = mreset();
    end else begin
      m4 = mstep(m4, 4, vio, vdd, sd);
      m1 = mstep(m1, 1, vio, vdd, sd);
    end
  end

  task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model plus the vswitch/en_h invariant
  always @(negedge clk) begin
    chk(32'(o4), 32'(m4.out), "cmp4");
    chk(32'(o1), 32'(m1.out), "cmp1");
    chk(32'(vs4 && !en4), 32'd0, "inv_vsw4");
    chk(32'(vs1 && !en1), 32'd0, "inv_vsw1");
`ifdef LA_IOPWRSEQ_STATUS_EN
    chk(32'(bo4), 32'(m4.bo), "bo4");
    chk(32'(bo1), 32'(m1.bo), "bo1");
    chk(32'(ev4), 32'(m4.ev), "ev4");
    chk(32'(ev1), 32'(m1.ev), "ev1");
`endif
  end

  // Count negedges until a u4 output bit reaches val; compare to hand-derived count
  task automatic meas(input int idx, input logic val, input int exp, input string nm);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < 200) begin
      @(negedge clk);
      n++;
      if (o4[idx] === val) hit = 1'b1;
    end
    chk(32'(n), 32'(exp), nm);
  endtask

  task automatic sd_pulse();
    sd = 1'b1;
    @(negedge clk);
    sd = 1'b0;
  endtask

  initial begin
    reset = 1'b1; vio = 1'b0; vdd = 1'b0; sd = 1'b0;
    repeat (3) @(negedge clk);
    chk(32'(o4), 32'h04, "rst_out4");
    chk(32'(o1), 32'h04, "rst_out1");
    reset = 1'b0;
    @(negedge clk);

    // Power-up
    vio = 1'b1; vdd = 1'b1;
    meas(4, 1'b1, SYNCN + 2, "up_en");
    meas(3, 1'b1, 4, "up_vsw");
    meas(2, 1'b0, 4, "up_hold");
    meas(1, 1'b1, 4, "up_nrst");
    chk(32'(rdy4), 32'd1, "up_ready");
    repeat (3) @(negedge clk);

    // Orderly shutdown and automatic re-up
    sd_pulse();
    chk(32'(nr4), 32'd1, "sd_nrst_lag");
    meas(1, 1'b0, 1, "sd_nrst");
    chk(32'(hold4), 32'd1, "sd_hold");
    meas(3, 1'b0, 4, "sd_vsw");
    meas(4, 1'b0, 4, "sd_en");
    meas(4, 1'b1, 5, "reup_en");
    meas(1, 1'b1, 12, "reup_nrst");

    // Abort during VSW_UP: cycle down and back up to the vswitch step first
    sd_pulse();
    meas(1, 1'b0, 1, "ab_sd_nrst");
    meas(3, 1'b0, 4, "ab_sd_vsw");
    meas(4, 1'b0, 4, "ab_sd_en");
    meas(4, 1'b1, 5, "ab_up_en");
    meas(3, 1'b1, 4, "ab_up_vsw");
    vdd = 1'b0;
    meas(3, 1'b0, 8, "ab_vsw_dn");
    chk(32'(hold4), 32'd1, "ab_hold");
    meas(4, 1'b0, 4, "ab_en_dn");
    repeat (8) @(negedge clk);
    chk(32'(o4), 32'h04, "ab_off");
    vdd = 1'b1;
    meas(4, 1'b1, SYNCN + 2, "ab_reup_en");
    meas(1, 1'b1, 12, "ab_reup_nrst");

    // Short vddio glitch while ON
    vio = 1'b0;
    repeat (SYNCN + 1) @(negedge clk);
    vio = 1'b1;
    meas(1, 1'b0, 1, "gl_nrst");
    meas(4, 1'b0, 8, "gl_en_dn");
    meas(4, 1'b1, 5, "gl_reup_en");
`ifdef LA_IOPWRSEQ_STATUS_EN
    chk(32'(bo4), 32'd1, "gl_brownout");
    chk(32'(ev4), 32'd3, "gl_event_cnt");
`endif

    // Async reset while in UNHOLD
    meas(2, 1'b0, 8, "gl_hold");
    #2 reset = 1'b1;
    #1;
    chk(32'(o4), 32'h04, "ar_out4");
    chk(32'(o1), 32'h04, "ar_out1");
    @(negedge clk);
`ifdef LA_IOPWRSEQ_STATUS_EN
    chk(32'(bo4), 32'd0, "ar_brownout");
    chk(32'(ev4), 32'd0, "ar_event_cnt");
`endif
    reset = 1'b0;
    meas(4, 1'b1, SYNCN + 2, "rs_reup_en");
    meas(1, 1'b1, 12, "rs_reup_nrst");
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
